// File: rtl/vmem_arb_pkg.sv
// rtl/vmem_arb_pkg.sv - shared types, widths and helpers for the video-memory bus arbiter
package vmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int VMEM_ADDR_W  = 22;
    // Widest requester vector the index helper understands
    localparam int VMEM_MAX_REQ = 8;

    // Index of the set bit in a one-hot vector; 0 when the vector is empty
    function automatic int unsigned onehot_to_index(input logic [VMEM_MAX_REQ-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < VMEM_MAX_REQ; i++) begin
            if (oh[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/vmem_arb_pick.sv
// rtl/vmem_arb_pick.sv - combinational winner picker, search starts at i_start and wraps
module vmem_arb_pick #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic [N-1:0]     o_onehot,
    output logic             o_valid
);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_hi;
    logic [N-1:0] w_sel;

    // Mask of requesters at or above the start index (the first leg of the wrap)
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (i >= int'(i_start));
        end
    end

    // Prefer the upper leg; fall back to the full vector once the search wraps.
    // Lowest set bit is isolated with the two's-complement trick.
    assign w_hi     = i_req & w_mask;
    assign w_sel    = (|w_hi) ? w_hi : i_req;
    assign o_onehot = w_sel & (~w_sel + N'(1));
    assign o_valid  = |i_req;

endmodule

// File: rtl/vmem_bus_arbiter.sv
// rtl/vmem_bus_arbiter.sv - whole-transaction video-memory read arbiter (VMEM_ARB_ROUND_ROBIN_EN selects round-robin)
module vmem_bus_arbiter
    import vmem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = VMEM_ADDR_W
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
    input  logic [NUM_REQ-1:0]          req_as,
    output logic [15:0]                 req_din,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic [ADDR_W-1:0]           mem_address,
    output logic                        mem_as,
    input  logic [15:0]                 mem_din,
    input  logic                        mem_ack,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        busy,
    output logic [15:0]                 ack_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [NUM_REQ-1:0] w_pick_oh;
    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_owner;
    logic [IDX_W-1:0]   w_start;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic               w_owner_as;
    logic               w_release;
    logic [15:0]        r_ack_count;

    assign w_owner    = IDX_W'(onehot_to_index(VMEM_MAX_REQ'(r_grant)));
    assign w_owner_as = |(req_as & r_grant);
    assign w_release  = (r_state == OWNED) && !w_owner_as;
    assign w_ptr_nxt  = (int'(w_owner) == NUM_REQ - 1) ? '0 : w_owner + IDX_W'(1);

`ifdef VMEM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_ptr;

    // Round-robin pointer moves past the owner as it gives up the bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (w_release) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign w_start = r_ptr;
`else
    // Fixed priority: search always begins at ICA0; next-pointer value is unused
    assign w_start = '0;
    logic w_unused_ptr;
    assign w_unused_ptr = ^w_ptr_nxt;
`endif

    vmem_arb_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req    (req_as),
        .i_start  (w_start),
        .o_onehot (w_pick_oh),
        .o_valid  (w_pick_valid)
    );

    // State and grant registers; reset drops ownership at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    // Next-state: grant on any request, hold until the owner drops as, then one dead cycle
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = OWNED;
                    w_grant_nxt = w_pick_oh;
                end
            end
            OWNED: begin
                if (!w_owner_as) begin
                    w_state_nxt = RELEASE;
                    w_grant_nxt = '0;
                end
            end
            RELEASE: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Count every acknowledged word delivered to an owner
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack_count <= '0;
        end else if (busy && mem_ack) begin
            r_ack_count <= r_ack_count + 16'd1;
        end
    end

    assign busy        = (r_state == OWNED);
    assign grant       = r_grant;
    assign mem_as      = busy & w_owner_as;
    assign mem_address = busy ? req_address[int'(w_owner)*ADDR_W +: ADDR_W] : '0;
    assign req_ack     = (busy && mem_ack) ? r_grant : '0;
    assign req_din     = mem_din;
    assign ack_count   = r_ack_count;

endmodule
